// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of a two-deep IF/ID stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // MIPS sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter that sticks at all-ones.
// Latency: count reflects inc one negedge later.
// Backpressure: none; inc is sampled every cycle.
// Ports: clock (negedge), reset_n (async, active-low), inc, count[W-1:0].
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with valid/ready handshake, one-entry skid and flush.
// Latency: 1 negedge from input transfer to out_valid; 1 instr/cycle streaming.
// Backpressure: in_ready lags out_ready by a cycle; the skid entry absorbs the in-flight instruction.
// Ports: clock (negedge), reset_n (async, active-low); fetch side in_valid/in_ready/in_ia/in_id;
//        flush; decode side out_valid/out_ready/out_ia/out_id; stall_cnt/bubble_cnt/flush_cnt.
// Define IFID_STAGE_PERF_EN to build the saturating performance counters; otherwise they read 0.
module ifid_stage
  import pipe_pkg::*;
#(
  parameter int          IA_W     = 32,
  parameter int          ID_W     = 32,
  parameter logic [31:0] NOP_WORD = MIPS_NOP,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IA_W-1:0]  in_ia,
  input  logic [ID_W-1:0]  in_id,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IA_W-1:0]  out_ia,
  output logic [ID_W-1:0]  out_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [ID_W-1:0] NOP_ID = ID_W'(NOP_WORD);

  pipe_state_t     state_q, state_d;
  logic [IA_W-1:0] main_ia_q, main_ia_d;
  logic [ID_W-1:0] main_id_q, main_id_d;
  logic [IA_W-1:0] skid_ia_q, skid_ia_d;
  logic [ID_W-1:0] skid_id_q, skid_id_d;

  always_comb begin
    state_d   = state_q;
    main_ia_d = main_ia_q;
    main_id_d = main_id_q;
    skid_ia_d = skid_ia_q;
    skid_id_d = skid_id_q;
    // Flush wins over everything, including an input offered while in_ready=1;
    // fetch is redirected by the same event so that word must not enter.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d   = FULL;
            main_ia_d = in_ia;
            main_id_d = in_id;
          end
        end
        FULL: begin
          if (out_ready && in_valid) begin
            main_ia_d = in_ia;
            main_id_d = in_id;
          end else if (out_ready) begin
            state_d = EMPTY;
          end else if (in_valid) begin
            // Decode stalled but fetch had already committed: park it.
            state_d   = SKID;
            skid_ia_d = in_ia;
            skid_id_d = in_id;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_d   = FULL;
            main_ia_d = skid_ia_q;
            main_id_d = skid_id_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      main_ia_q <= '0;
      main_id_q <= NOP_ID;
      skid_ia_q <= '0;
      skid_id_q <= '0;
    end else begin
      state_q   <= state_d;
      main_ia_q <= main_ia_d;
      main_id_q <= main_id_d;
      skid_ia_q <= skid_ia_d;
      skid_id_q <= skid_id_d;
    end
  end

  // Both handshake outputs come straight from the state flops.
  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_ia    = main_ia_q;
  assign out_id    = (state_q == EMPTY) ? NOP_ID : main_id_q;

`ifdef IFID_STAGE_PERF_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (out_valid && !out_ready),
    .count   (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (!out_valid),
    .count   (bubble_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush),
    .count   (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
